booth_calc_sequencer: RTL and testbench
=======================================

Name: booth_calc_sequencer

Overview:
- Top-level entry and run controller for the keypad-driven Booth multiplier calculator.
- Classifies decoded keypad events and drives the operand-storage enables (A, B, sign) and per-operand sign flags.
- Issues a one-cycle start to the Booth multiplier, waits for its done, and selects what the display shows.
- Sits between the keypad decoder/debouncer and the number-storage + multiplier datapath.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits accepted per operand; further digits are dropped.
- TIMEOUT_CYC, 64, cycles allowed between start_mult and mult_done before error (only with the optional feature).
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- key_valid  in  1  one-cycle pulse per debounced, synchronised key press.
- key_code  in  4  key code: 0-9 digit, A multiply/confirm-A, B sign toggle, C clear, D equals/confirm-B, E-F unused.
- mult_done  in  1  one-cycle pulse from the multiplier when the product is valid.
- enable_A  out  1  storage writes operand A.
- enable_B  out  1  storage writes operand B.
- enable_sign  out  1  one-cycle pulse on an accepted sign key.
- sign_A  out  1  1 = operand A negative.
- sign_B  out  1  1 = operand B negative.
- digit_load  out  1  one-cycle pulse: accepted digit, storage shifts in key_code.
- clear_store  out  1  one-cycle pulse: storage clears temp, A and B.
- start_mult  out  1  one-cycle multiplier start.
- digit_cnt  out  2  digits accepted for the current operand.
- disp_sel  out  2  display source: 0 entry value, 1 product, 2 error.
- error  out  1  sticky multiplier timeout; cleared only by the C key or reset.

Behaviour:
- States: ENTER_A, ENTER_B, START, WAIT, SHOW, ERR.
- Reset values: state ENTER_A; enable_A 1; all other outputs 0.
- All outputs are registered. A key accepted in cycle n produces its pulse outputs and state change at edge n+1.
- ENTER_A (enable_A=1):
  - Digit with digit_cnt<MAX_DIGITS: digit_load pulse, digit_cnt+1.
  - Digit at MAX_DIGITS: ignored.
  - B: toggle sign_A, enable_sign pulse.
  - A: go to ENTER_B, digit_cnt=0. Pressing A with digit_cnt=0 is valid and yields A=0.
  - D: ignored.
- ENTER_B (enable_B=1): same digit and sign rules, applied to sign_B.
  - D: go to START.
  - A: ignored.
- START: start_mult=1 for exactly one cycle, then go to WAIT. Timeout counter loads 0.
- WAIT: all keys except C are ignored. mult_done goes to SHOW.
- SHOW: disp_sel=1.
  - Digit key: clear_store pulse, go to ENTER_A with sign_A/sign_B=0. That first digit is not loaded.
  - A, B and D are ignored.
- ERR: disp_sel=2, error=1. Only C leaves this state.
- C key in any state: clear_store pulse, state ENTER_A, signs 0, digit_cnt 0, error 0, counter 0.
- Simultaneous events:
  - C with mult_done in WAIT: C wins and the product is discarded.
  - mult_done outside WAIT: ignored.
  - key_valid while in START: ignored.
- disp_sel=0 in ENTER_A and ENTER_B.
- Asynchronous reset mid-operation returns to ENTER_A immediately. No start pulse is generated during or after reset.
- enable_A and enable_B are never both 1.

Optional Feature:
- Macro: BOOTH_SEQ_TIMEOUT_EN.
- With the macro: WAIT increments a CNT_W-bit counter each cycle. Reaching TIMEOUT_CYC without mult_done goes to ERR. mult_done in the same cycle as the limit wins and goes to SHOW.
- Without the macro: no counter exists, WAIT waits indefinitely, ERR is unreachable, and error is tied 0.

Decomposition:
- Shared package booth_calc_pkg holds:
  - state enum calc_state_t;
  - key code constants KEY_MUL=4'hA, KEY_SIGN=4'hB, KEY_CLR=4'hC, KEY_EQ=4'hD;
  - disp_sel constants DISP_ENTRY, DISP_PROD, DISP_ERR.
- One sub-module, key_classifier: combinational decode of key_code into is_digit, is_mul, is_sign, is_clr, is_eq, gated by key_valid. The FSM stays in the top module.

Test Plan:
- Keys 1,2 in ENTER_A -> two digit_load pulses, digit_cnt=2, enable_A=1, enable_B=0.
- Keys 1,2,3,4 -> only three digit_load pulses, digit_cnt=3.
- Keys 7,B,A,5,D -> sign_A=1, sign_B=0; state ENTER_B after A; one start_mult pulse after D.
- mult_done 10 cycles later -> SHOW, disp_sel=1. Then key 4 -> clear_store pulse, ENTER_A, no digit_load.
- With BOOTH_SEQ_TIMEOUT_EN and no mult_done for 64 cycles -> ERR, error=1, disp_sel=2. Then C -> ENTER_A, error=0.
- In WAIT, drive C and mult_done in the same cycle -> ENTER_A, disp_sel=0. Reset asserted in START -> no start_mult, enable_A=1.

Source files
------------

// File: rtl/booth_calc_sequencer_pkg.sv
// Shared types and constants for the Booth calculator sequencer slice.
// Optional multiplier timeout is enabled by defining BOOTH_SEQ_TIMEOUT_EN.
package booth_calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        SHOW,
        ERR
    } calc_state_t;

    localparam logic [3:0] KEY_MUL  = 4'hA;
    localparam logic [3:0] KEY_SIGN = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;
    localparam logic [3:0] KEY_EQ   = 4'hD;

    localparam logic [1:0] DISP_ENTRY = 2'd0;
    localparam logic [1:0] DISP_PROD  = 2'd1;
    localparam logic [1:0] DISP_ERR   = 2'd2;

    function automatic logic [1:0] disp_for_state(input calc_state_t s);
        case (s)
            SHOW:    return DISP_PROD;
            ERR:     return DISP_ERR;
            default: return DISP_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/booth_calc_sequencer_if.sv
// Key/handshake bundle between keypad decoder, sequencer and storage/multiplier.
// slave is the sequencer side; master is the keypad/datapath side.
interface booth_calc_sequencer_if;

    logic       key_valid;
    logic [3:0] key_code;
    logic       mult_done;
    logic       enable_A;
    logic       enable_B;
    logic       enable_sign;
    logic       sign_A;
    logic       sign_B;
    logic       digit_load;
    logic       clear_store;
    logic       start_mult;
    logic [1:0] digit_cnt;
    logic [1:0] disp_sel;
    logic       error;

    modport slave (
        input  key_valid, key_code, mult_done,
        output enable_A, enable_B, enable_sign, sign_A, sign_B, digit_load,
               clear_store, start_mult, digit_cnt, disp_sel, error
    );

    modport master (
        output key_valid, key_code, mult_done,
        input  enable_A, enable_B, enable_sign, sign_A, sign_B, digit_load,
               clear_store, start_mult, digit_cnt, disp_sel, error
    );

endinterface

// File: rtl/booth_calc_sequencer_key_classifier.sv
// Combinational decode of a keypad code into one-hot key classes, gated by key_valid.
// Codes E and F decode to no class and are therefore ignored downstream.
module key_classifier
    import booth_calc_pkg::*;
(
    input  logic       key_valid_i,
    input  logic [3:0] key_code_i,
    output logic       is_digit_o,
    output logic       is_mul_o,
    output logic       is_sign_o,
    output logic       is_clr_o,
    output logic       is_eq_o
);

    always_comb begin
        is_digit_o = key_valid_i && (key_code_i <= 4'd9);
        is_mul_o   = key_valid_i && (key_code_i == KEY_MUL);
        is_sign_o  = key_valid_i && (key_code_i == KEY_SIGN);
        is_clr_o   = key_valid_i && (key_code_i == KEY_CLR);
        is_eq_o    = key_valid_i && (key_code_i == KEY_EQ);
    end

endmodule

// File: rtl/booth_calc_sequencer.sv
// Keypad-driven run controller for the Booth multiplier calculator; all outputs registered.
// Define BOOTH_SEQ_TIMEOUT_EN to add the multiplier timeout counter and ERR path.
module booth_calc_sequencer
    import booth_calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS  = 3,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_calc_sequencer_if.slave bus
);

    if ((MAX_DIGITS > 3) || ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYC))) begin : g_param_chk
        $error("booth_calc_sequencer: MAX_DIGITS must fit digit_cnt and 2^CNT_W must exceed TIMEOUT_CYC");
    end

    localparam logic [1:0] MAX_D = 2'(MAX_DIGITS);

    logic is_digit, is_mul, is_sign, is_clr, is_eq;
    logic timeout_hit;

    calc_state_t state_q, state_d;
    logic       sign_a_q, sign_a_d;
    logic       sign_b_q, sign_b_d;
    logic [1:0] digit_cnt_q, digit_cnt_d;
    logic       digit_load_q, digit_load_d;
    logic       clear_store_q, clear_store_d;
    logic       enable_sign_q, enable_sign_d;
    logic       start_mult_q;
    logic       enable_a_q;
    logic       enable_b_q;
    logic [1:0] disp_sel_q;

    key_classifier u_key_classifier (
        .key_valid_i (bus.key_valid),
        .key_code_i  (bus.key_code),
        .is_digit_o  (is_digit),
        .is_mul_o    (is_mul),
        .is_sign_o   (is_sign),
        .is_clr_o    (is_clr),
        .is_eq_o     (is_eq)
    );

    always_comb begin
        logic go_clear;
        go_clear      = 1'b0;
        state_d       = state_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        digit_cnt_d   = digit_cnt_q;
        digit_load_d  = 1'b0;
        clear_store_d = 1'b0;
        enable_sign_d = 1'b0;

        case (state_q)
            ENTER_A: begin
                if (is_digit && (digit_cnt_q < MAX_D)) begin
                    digit_load_d = 1'b1;
                    digit_cnt_d  = digit_cnt_q + 2'd1;
                end else if (is_sign) begin
                    sign_a_d      = ~sign_a_q;
                    enable_sign_d = 1'b1;
                end else if (is_mul) begin
                    state_d     = ENTER_B;
                    digit_cnt_d = '0;
                end
            end
            ENTER_B: begin
                if (is_digit && (digit_cnt_q < MAX_D)) begin
                    digit_load_d = 1'b1;
                    digit_cnt_d  = digit_cnt_q + 2'd1;
                end else if (is_sign) begin
                    sign_b_d      = ~sign_b_q;
                    enable_sign_d = 1'b1;
                end else if (is_eq) begin
                    state_d = START;
                end
            end
            START:   state_d = WAIT;
            WAIT: begin
                if (bus.mult_done) begin
                    state_d = SHOW;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            SHOW:    go_clear = is_digit;
            ERR:     ;
            default: state_d = ENTER_A;
        endcase

        // START is a single fixed cycle: every key, C included, is dropped there.
        if (is_clr && (state_q != START)) begin
            go_clear = 1'b1;
        end

        if (go_clear) begin
            state_d       = ENTER_A;
            sign_a_d      = 1'b0;
            sign_b_d      = 1'b0;
            digit_cnt_d   = '0;
            digit_load_d  = 1'b0;
            enable_sign_d = 1'b0;
            clear_store_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ENTER_A;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            digit_cnt_q   <= '0;
            digit_load_q  <= 1'b0;
            clear_store_q <= 1'b0;
            enable_sign_q <= 1'b0;
            start_mult_q  <= 1'b0;
            enable_a_q    <= 1'b1;
            enable_b_q    <= 1'b0;
            disp_sel_q    <= DISP_ENTRY;
        end else begin
            state_q       <= state_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            digit_cnt_q   <= digit_cnt_d;
            digit_load_q  <= digit_load_d;
            clear_store_q <= clear_store_d;
            enable_sign_q <= enable_sign_d;
            start_mult_q  <= (state_d == START);
            enable_a_q    <= (state_d == ENTER_A);
            enable_b_q    <= (state_d == ENTER_B);
            disp_sel_q    <= disp_for_state(state_d);
        end
    end

`ifdef BOOTH_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             error_q;

    // Counts completed WAIT cycles; zero everywhere else, so START and C both reload it.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == WAIT) && (state_d == WAIT)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            error_q   <= (state_d == ERR);
        end
    end

    assign bus.error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.error   = 1'b0;
`endif

    assign bus.enable_A    = enable_a_q;
    assign bus.enable_B    = enable_b_q;
    assign bus.enable_sign = enable_sign_q;
    assign bus.sign_A      = sign_a_q;
    assign bus.sign_B      = sign_b_q;
    assign bus.digit_load  = digit_load_q;
    assign bus.clear_store = clear_store_q;
    assign bus.start_mult  = start_mult_q;
    assign bus.digit_cnt   = digit_cnt_q;
    assign bus.disp_sel    = disp_sel_q;

endmodule

// File: tb/tb_booth_calc_sequencer.sv
// Self-checking bench for booth_calc_sequencer: behavioural model compared every cycle
// plus hand-computed literal expectations; covers the timeout path when BOOTH_SEQ_TIMEOUT_EN is set.
module tb_booth_calc_sequencer;

    localparam int PH_A    = 0;
    localparam int PH_B    = 1;
    localparam int PH_GO   = 2;
    localparam int PH_WAIT = 3;
    localparam int PH_SHOW = 4;
    localparam int PH_ERR  = 5;
    localparam int TMO     = 64;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   n_loads  = 0;

    booth_calc_sequencer_if bus ();

    booth_calc_sequencer #(
        .MAX_DIGITS  (3),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase of the calculation plus the visible operand state.
    int m_phase = PH_A;
    int m_cnt   = 0;
    int m_wait  = 0;
    bit m_sa    = 0;
    bit m_sb    = 0;
    bit m_load  = 0;
    bit m_clr   = 0;
    bit m_sgn   = 0;

    function automatic void m_clear();
        m_phase = PH_A;
        m_sa    = 0;
        m_sb    = 0;
        m_cnt   = 0;
        m_clr   = 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = PH_A;
            m_cnt   = 0;
            m_wait  = 0;
            m_sa    = 0;
            m_sb    = 0;
            m_load  = 0;
            m_clr   = 0;
            m_sgn   = 0;
        end else begin
            int  k;
            bit  kv;
            bit  dig;
            kv     = (bus.key_valid === 1'b1);
            k      = int'(bus.key_code);
            dig    = kv && (k <= 9);
            m_load = 0;
            m_clr  = 0;
            m_sgn  = 0;
            if (m_phase == PH_GO) begin
                m_phase = PH_WAIT;
                m_wait  = 0;
            end else if (kv && k == 12) begin
                m_clear();
            end else begin
                case (m_phase)
                    PH_A, PH_B: begin
                        if (dig) begin
                            if (m_cnt < 3) begin
                                m_load = 1;
                                m_cnt++;
                            end
                        end else if (kv && k == 11) begin
                            m_sgn = 1;
                            if (m_phase == PH_A) m_sa = !m_sa;
                            else                 m_sb = !m_sb;
                        end else if (kv && k == 10 && m_phase == PH_A) begin
                            m_phase = PH_B;
                            m_cnt   = 0;
                        end else if (kv && k == 13 && m_phase == PH_B) begin
                            m_phase = PH_GO;
                        end
                    end
                    PH_WAIT: begin
                        if (bus.mult_done === 1'b1) begin
                            m_phase = PH_SHOW;
                        end else begin
                            m_wait++;
`ifdef BOOTH_SEQ_TIMEOUT_EN
                            if (m_wait == TMO) m_phase = PH_ERR;
`endif
                        end
                    end
                    PH_SHOW: if (dig) m_clear();
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        int exp_disp;
        exp_disp = (m_phase == PH_SHOW) ? 1 : (m_phase == PH_ERR) ? 2 : 0;
        chk("m_enable_A",    int'(bus.enable_A),    int'(m_phase == PH_A));
        chk("m_enable_B",    int'(bus.enable_B),    int'(m_phase == PH_B));
        chk("m_start_mult",  int'(bus.start_mult),  int'(m_phase == PH_GO));
        chk("m_disp_sel",    int'(bus.disp_sel),    exp_disp);
        chk("m_error",       int'(bus.error),       int'(m_phase == PH_ERR));
        chk("m_sign_A",      int'(bus.sign_A),      int'(m_sa));
        chk("m_sign_B",      int'(bus.sign_B),      int'(m_sb));
        chk("m_digit_cnt",   int'(bus.digit_cnt),   m_cnt);
        chk("m_digit_load",  int'(bus.digit_load),  int'(m_load));
        chk("m_clear_store", int'(bus.clear_store), int'(m_clr));
        chk("m_enable_sign", int'(bus.enable_sign), int'(m_sgn));
        if (bus.digit_load === 1'b1) n_loads++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        cyc(1);
        bus.key_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.mult_done = 1'b1;
        cyc(1);
        bus.mult_done = 1'b0;
    endtask

    initial begin
        int waited;
        rst           = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.mult_done = 1'b0;
        cyc(2);
        chk("reset_enable_A",  int'(bus.enable_A),   1);
        chk("reset_start",     int'(bus.start_mult), 0);
        chk("reset_disp",      int'(bus.disp_sel),   0);
        rst = 1'b1;
        cyc(1);

        n_loads = 0;
        press(4'h1); press(4'h2); cyc(1);
        chk("two_digits_loads", n_loads, 2);
        chk("two_digits_cnt",   int'(bus.digit_cnt), 2);
        chk("two_digits_enB",   int'(bus.enable_B),  0);
        press(4'hC);
        chk("clear_pulse", int'(bus.clear_store), 1);
        chk("clear_cnt",   int'(bus.digit_cnt),   0);
        cyc(1);

        n_loads = 0;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); cyc(1);
        chk("four_digits_loads", n_loads, 3);
        chk("four_digits_cnt",   int'(bus.digit_cnt), 3);
        press(4'hC); cyc(1);

        press(4'h7); press(4'hB);
        chk("sign_pulse",  int'(bus.enable_sign), 1);
        chk("sign_A_set",  int'(bus.sign_A),      1);
        press(4'hD); cyc(1);
        chk("eq_ignored_in_A", int'(bus.enable_A), 1);
        press(4'hA);
        chk("enter_B_enB", int'(bus.enable_B),  1);
        chk("enter_B_enA", int'(bus.enable_A),  0);
        chk("enter_B_cnt", int'(bus.digit_cnt), 0);
        press(4'h5); press(4'hA); press(4'hD);
        chk("start_pulse", int'(bus.start_mult), 1);
        chk("start_signA", int'(bus.sign_A),     1);
        chk("start_signB", int'(bus.sign_B),     0);
        cyc(1);
        chk("start_one_cycle", int'(bus.start_mult), 0);
        cyc(8);
        pulse_done();
        chk("show_disp", int'(bus.disp_sel), 1);
        press(4'hA); press(4'hB); press(4'hD); cyc(1);
        chk("show_keys_ignored", int'(bus.disp_sel), 1);
        n_loads = 0;
        press(4'h4);
        chk("show_digit_clear", int'(bus.clear_store), 1);
        chk("show_digit_enA",   int'(bus.enable_A),    1);
        chk("show_digit_signA", int'(bus.sign_A),      0);
        cyc(1);
        chk("show_digit_noload", n_loads, 0);

        press(4'h2); press(4'hA); press(4'hB); press(4'h9); press(4'hD);
        waited = 0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
        while (waited < 80 && bus.disp_sel != 2'd2) begin
            cyc(1);
            waited++;
        end
        chk("timeout_cycles", waited, TMO + 1);
        chk("timeout_error",  int'(bus.error), 1);
        pulse_done();
        chk("done_in_err_ignored", int'(bus.disp_sel), 2);
        press(4'hC);
        chk("err_clear_error", int'(bus.error),    0);
        chk("err_clear_enA",   int'(bus.enable_A), 1);
`else
        cyc(100);
        chk("no_timeout_disp",  int'(bus.disp_sel), 0);
        chk("no_timeout_error", int'(bus.error),    0);
        pulse_done();
        chk("late_done_show", int'(bus.disp_sel), 1);
        press(4'hC);
`endif
        cyc(1);

        press(4'hA); press(4'hD); cyc(2);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'hC;
        bus.mult_done = 1'b1;
        cyc(1);
        bus.key_valid = 1'b0;
        bus.mult_done = 1'b0;
        chk("c_beats_done_disp", int'(bus.disp_sel),    0);
        chk("c_beats_done_enA",  int'(bus.enable_A),    1);
        cyc(2);
        chk("c_beats_done_stays", int'(bus.disp_sel), 0);

        pulse_done();
        chk("stray_done_disp", int'(bus.disp_sel), 0);

        press(4'hA); press(4'hD);
        press(4'hC);
        chk("key_in_start_ignored", int'(bus.clear_store), 0);
        press(4'hC); cyc(1);

        press(4'hA); press(4'hD);
        #2 rst = 1'b0;
        #1;
        chk("reset_in_start_pulse", int'(bus.start_mult), 0);
        chk("reset_in_start_enA",   int'(bus.enable_A),   1);
        cyc(2);
        rst = 1'b1;
        cyc(3);
        chk("after_reset_start", int'(bus.start_mult), 0);
        chk("after_reset_enA",   int'(bus.enable_A),   1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
